// File: rtl/dmac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmac_pkg
//  Description : Shared types and constants for the DMAC request front end:
//                per-channel handshake state encoding, channel count and
//                ReqAck grant codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmac_pkg;

    // Per-channel 4-phase handshake states
    typedef enum logic [1:0] {
        RQ_IDLE   = 2'd0,
        RQ_PEND   = 2'd1,
        RQ_ACTIVE = 2'd2,
        RQ_DONE   = 2'd3
    } req_state_t;

    localparam int DMAC_NUM_CH = 2;

    // ReqAck codes from the main controller (bit1 = ch1, bit0 = ch2)
    localparam logic [1:0] ACK_CH1 = 2'b10;
    localparam logic [1:0] ACK_CH2 = 2'b01;

endpackage : dmac_pkg
`default_nettype wire

// File: rtl/dmac_req_chan.sv
`default_nettype none
// ============================================================================
//  Module      : dmac_req_chan
//  Description : One DMAC request channel: PerReq synchroniser followed by
//                the 4-phase handshake FSM. With DMAC_REQ_TIMEOUT_EN defined
//                an ACTIVE-state watchdog aborts a stalled transfer and pulses
//                o_err for one cycle.
//  Config      : DMAC_REQ_TIMEOUT_EN (optional watchdog)
//  Revision    : 1.0 - initial release
// ============================================================================
module dmac_req_chan
    import dmac_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_per_req,     // raw asynchronous peripheral request
    input  logic i_ack,         // grant for this channel (already de-conflicted)
    input  logic i_intr,        // transfer-complete pulse
    input  logic i_any_active,  // some channel (maybe this one) is ACTIVE
    output logic o_pend,
    output logic o_active,
    output logic o_done,
    output logic o_err
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_req_s;
    logic                   w_timeout_hit;
    req_state_t             r_state;
    req_state_t             w_state_nxt;

    // Synchroniser shift chain for the asynchronous request line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_per_req};
        end
    end

    assign w_req_s = r_sync[SYNC_STAGES-1];

`ifdef DMAC_REQ_TIMEOUT_EN
    localparam int                CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // Watchdog: zero outside ACTIVE so it reads 0 on the first ACTIVE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state != RQ_ACTIVE) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_timeout_hit = (r_state == RQ_ACTIVE) && (r_cnt == c_cnt_last);

    // Abort flag: a coincident Interrupt completes the transfer normally instead
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout_hit && !i_intr;
        end
    end

    assign o_err = r_err;
`else
    assign w_timeout_hit = 1'b0;
    assign o_err         = 1'b0;
`endif

    // Handshake state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RQ_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a grant in PEND wins over a same-cycle withdrawal
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RQ_IDLE: begin
                if (w_req_s) begin
                    w_state_nxt = RQ_PEND;
                end
            end
            RQ_PEND: begin
                if (i_ack && !i_any_active) begin
                    w_state_nxt = RQ_ACTIVE;
                end else if (!w_req_s) begin
                    w_state_nxt = RQ_IDLE;
                end
            end
            RQ_ACTIVE: begin
                if (i_intr) begin
                    w_state_nxt = RQ_DONE;
                end else if (w_timeout_hit) begin
                    w_state_nxt = RQ_IDLE;
                end
            end
            RQ_DONE: begin
                if (!w_req_s) begin
                    w_state_nxt = RQ_IDLE;
                end
            end
            default: begin
                w_state_nxt = RQ_IDLE;
            end
        endcase
    end

    assign o_pend   = (r_state == RQ_PEND);
    assign o_active = (r_state == RQ_ACTIVE);
    assign o_done   = (r_state == RQ_DONE);

`ifndef SYNTHESIS
    a_param_legal : assert property (@(posedge clk) disable iff (!rst_n)
        (SYNC_STAGES >= 2) && (SYNC_STAGES <= 4) && (TIMEOUT_CYCLES >= 2))
        else $error("dmac_req_chan: illegal SYNC_STAGES/TIMEOUT_CYCLES");
`endif

endmodule : dmac_req_chan
`default_nettype wire

// File: rtl/dmac_req_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmac_req_if
//  Description : Peripheral-side request front end of the DMAC. Two request
//                channels (bit1 = ch1, bit0 = ch2), each synchronised and run
//                through a 4-phase handshake. Presents DmacReq to the main
//                controller and returns PerAck to the peripherals.
//  Config      : DMAC_REQ_TIMEOUT_EN enables the ACTIVE watchdog / ReqErr.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmac_req_if
    import dmac_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,        // asynchronous, active-low
    input  logic [1:0] PerReq,
    input  logic [1:0] ReqAck,
    input  logic       Interrupt,
    output logic [1:0] DmacReq,
    output logic [1:0] PerAck,
    output logic [1:0] ReqErr
);

    logic [DMAC_NUM_CH-1:0] w_ack;
    logic [DMAC_NUM_CH-1:0] w_pend;
    logic [DMAC_NUM_CH-1:0] w_active;
    logic [DMAC_NUM_CH-1:0] w_done;
    logic [DMAC_NUM_CH-1:0] w_err;
    logic                   w_any_active;

    // An illegal double grant goes to ch1; ch2 stays pending
    assign w_ack        = (ReqAck == (ACK_CH1 | ACK_CH2)) ? ACK_CH1 : ReqAck;
    assign w_any_active = |w_active;

    for (genvar g = 0; g < DMAC_NUM_CH; g++) begin : g_chan
        dmac_req_chan #(
            .SYNC_STAGES    (SYNC_STAGES),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst),
            .i_per_req    (PerReq[g]),
            .i_ack        (w_ack[g]),
            .i_intr       (Interrupt),
            .i_any_active (w_any_active),
            .o_pend       (w_pend[g]),
            .o_active     (w_active[g]),
            .o_done       (w_done[g]),
            .o_err        (w_err[g])
        );
    end

    // Requests are hidden while a transfer is running on either channel
    assign DmacReq = w_any_active ? '0 : w_pend;
    assign PerAck  = w_done;
    assign ReqErr  = w_err;

`ifndef SYNTHESIS
    a_reqack_not_both : assert property (@(posedge clk) disable iff (!rst)
        ReqAck != (ACK_CH1 | ACK_CH2))
        else $error("dmac_req_if: ReqAck = 11 is illegal");

    a_single_active : assert property (@(posedge clk) disable iff (!rst)
        !(&w_active))
        else $error("dmac_req_if: both channels ACTIVE");
`endif

endmodule : dmac_req_if
`default_nettype wire
